// File: rtl/dmem_wait_port_if.sv
// Core-to-data-memory bus: request side driven by the core (master),
// response side driven by the wait-state memory port (slave).
interface dmem_wait_port_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  bytemask;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        stall;

  // Handshake: the core raises req and holds req/we/addr/wdata/bytemask
  // stable while stall=1; the access completes on the single cycle ack=1
  // (stall=0 there), with err=1 alongside ack for a rejected access.
  modport master (
    output req, we, addr, wdata, bytemask,
    input  rdata, ack, err, stall
  );

  modport slave (
    input  req, we, addr, wdata, bytemask,
    output rdata, ack, err, stall
  );
endinterface

// File: rtl/dmem_wait_port.sv
// Multi-cycle byte-masked data memory with LATENCY wait states, stalling the core.
// Optional performance counters are enabled with the DMEM_WAIT_PERF_EN macro.
module dmem_wait_port #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  dmem_wait_port_if.slave    bus,
  output logic [1:0]         dbg_state
`ifdef DMEM_WAIT_PERF_EN
  ,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count,
  output logic [31:0]        stall_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] addr_q;
  logic [3:0]    mask_q;
  logic [31:0]   rdata_q;
  logic          ack_q;
  logic          err_q;

  logic [31:0]   ram [DEPTH];

  logic          mask_ok;
  logic          addr_ok;
  logic          req_ok;
  logic          commit;
  logic          ram_we;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] commit_idx;
  logic [3:0]    commit_mask;
  logic [31:0]   bitmask;
  logic          unused_ok;

  always_comb begin
    mask_ok = 1'b0;
    case (bus.bytemask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_ok = 1'b1;
      default:                   mask_ok = 1'b0;
    endcase
  end

  assign addr_ok = (bus.addr[31:2] < 30'(DEPTH));
  assign req_ok  = mask_ok & addr_ok;
  assign req_idx = bus.addr[AW+1:2];

  // Commit edge: straight from IDLE when there are no extra wait states,
  // otherwise on the last WAIT cycle.
  assign commit = bus.req &
                  (((state == S_IDLE) && req_ok && (LATENCY == 1)) ||
                   ((state == S_WAIT) && (cnt == 4'd1)));

  assign commit_idx  = (state == S_IDLE) ? req_idx : addr_q;
  assign commit_mask = (state == S_IDLE) ? bus.bytemask : mask_q;
  assign bitmask     = {{8{commit_mask[3]}}, {8{commit_mask[2]}},
                        {8{commit_mask[1]}}, {8{commit_mask[0]}}};
  assign ram_we      = commit & bus.we & reset;

  assign bus.stall = bus.req & (state != S_DONE) & reset;
  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign dbg_state = state;
  assign unused_ok = ^bus.addr[1:0];

  always_ff @(posedge clk) begin
    if (ram_we)
      ram[commit_idx] <= (ram[commit_idx] & ~bitmask) | (bus.wdata & bitmask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      mask_q  <= 4'd0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            if (!req_ok) begin
              state   <= S_DONE;
              ack_q   <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
            end else begin
              addr_q <= req_idx;
              mask_q <= bus.bytemask;
              cnt    <= 4'(LATENCY - 1);
              if (commit) begin
                state <= S_DONE;
                ack_q <= 1'b1;
                if (!bus.we)
                  rdata_q <= ram[commit_idx];
              end else begin
                state <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          // Dropping req mid-wait abandons the access with no side effects.
          if (!bus.req) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else if (commit) begin
            state <= S_DONE;
            ack_q <= 1'b1;
            cnt   <= 4'd0;
            if (!bus.we)
              rdata_q <= ram[commit_idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DMEM_WAIT_PERF_EN
  logic done_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_we     <= 1'b0;
      rd_count    <= 32'd0;
      wr_count    <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (commit)
        done_we <= bus.we;
      if ((state == S_DONE) && !err_q) begin
        if (done_we)
          wr_count <= wr_count + 32'd1;
        else
          rd_count <= rd_count + 32'd1;
      end
      if (bus.stall)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_wait_port.sv
// Directed bench for dmem_wait_port: three instances at LATENCY 1, 2 and 4
// sharing clock and reset, each driven through its own bus interface.
module tb_dmem_wait_port;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  dmem_wait_port_if if1 ();
  dmem_wait_port_if if2 ();
  dmem_wait_port_if if4 ();

  logic [1:0] st1, st2, st4;
`ifdef DMEM_WAIT_PERF_EN
  logic [31:0] rd1, wr1, sc1, rd2, wr2, sc2, rd4, wr4, sc4;
`endif

  dmem_wait_port #(.DEPTH(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave), .dbg_state(st1)
`ifdef DMEM_WAIT_PERF_EN
    , .rd_count(rd1), .wr_count(wr1), .stall_count(sc1)
`endif
  );

  dmem_wait_port #(.DEPTH(256), .LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(if2.slave), .dbg_state(st2)
`ifdef DMEM_WAIT_PERF_EN
    , .rd_count(rd2), .wr_count(wr2), .stall_count(sc2)
`endif
  );

  dmem_wait_port #(.DEPTH(256), .LATENCY(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(if4.slave), .dbg_state(st4)
`ifdef DMEM_WAIT_PERF_EN
    , .rd_count(rd4), .wr_count(wr4), .stall_count(sc4)
`endif
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Driver and observation helpers
  task automatic set_in(input int sel, input logic req, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask);
    case (sel)
      1: begin if1.req = req; if1.we = we; if1.addr = addr; if1.wdata = wdata; if1.bytemask = mask; end
      2: begin if2.req = req; if2.we = we; if2.addr = addr; if2.wdata = wdata; if2.bytemask = mask; end
      default: begin if4.req = req; if4.we = we; if4.addr = addr; if4.wdata = wdata; if4.bytemask = mask; end
    endcase
  endtask

  function automatic logic get_stall(input int sel);
    case (sel)
      1:       return if1.stall;
      2:       return if2.stall;
      default: return if4.stall;
    endcase
  endfunction

  function automatic logic get_ack(input int sel);
    case (sel)
      1:       return if1.ack;
      2:       return if2.ack;
      default: return if4.ack;
    endcase
  endfunction

  function automatic logic get_err(input int sel);
    case (sel)
      1:       return if1.err;
      2:       return if2.err;
      default: return if4.err;
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(input int sel);
    case (sel)
      1:       return if1.rdata;
      2:       return if2.rdata;
      default: return if4.rdata;
    endcase
  endfunction

  function automatic logic [1:0] get_state(input int sel);
    case (sel)
      1:       return st1;
      2:       return st2;
      default: return st4;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1 with the selected port idle.
  task automatic access(input int sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        output int stalls, output logic err, output logic [31:0] rdata);
    logic got;
    got    = 1'b0;
    stalls = 0;
    err    = 1'b0;
    rdata  = 32'd0;
    set_in(sel, 1'b1, we, addr, wdata, mask);
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (get_stall(sel)) stalls++;
      @(posedge clk); #1;
      if (get_ack(sel)) begin
        got   = 1'b1;
        err   = get_err(sel);
        rdata = get_rdata(sel);
      end
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    set_in(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_load(input int sel, input logic [31:0] addr, input logic [31:0] exp,
                         input int exp_st, input string tag);
    int st; logic e; logic [31:0] rd;
    access(sel, 1'b0, addr, 32'd0, 4'hF, st, e, rd);
    chk({tag, "_stall"}, st, exp_st);
    chk({tag, "_err"}, {31'd0, e}, 32'd0);
    chk({tag, "_rdata"}, rd, exp);
  endtask

  task automatic do_store(input int sel, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input int exp_st, input string tag);
    int st; logic e; logic [31:0] rd;
    access(sel, 1'b1, addr, wdata, mask, st, e, rd);
    chk({tag, "_stall"}, st, exp_st);
    chk({tag, "_err"}, {31'd0, e}, 32'd0);
  endtask

  task automatic do_bad(input int sel, input logic we, input logic [31:0] addr,
                        input logic [3:0] mask, input string tag);
    int st; logic e; logic [31:0] rd;
    access(sel, we, addr, 32'hFFFF_FFFF, mask, st, e, rd);
    chk({tag, "_stall"}, st, 1);
    chk({tag, "_err"}, {31'd0, e}, 32'd1);
    chk({tag, "_rdata"}, rd, 32'd0);
  endtask

  initial begin
    int st; logic e; logic [31:0] rd;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    set_in(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    set_in(2, 1'b1, 1'b0, 32'd0, 32'd0, 4'hF);
    set_in(4, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);

    // Reset state, stall suppressed while reset is low even with req=1
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, if2.ack}, 32'd0);
    chk("rst_err", {31'd0, if2.err}, 32'd0);
    chk("rst_rdata", if2.rdata, 32'd0);
    chk("rst_state", {30'd0, st2}, 32'd0);
    chk("rst_stall", {31'd0, if2.stall}, 32'd0);
    set_in(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Word store then load, LATENCY=2
    access(2, 1'b1, 32'h64, 32'h0000_0019, 4'hF, st, e, rd);
    chk("w_store_stall", st, 2);
    chk("w_store_err", {31'd0, e}, 32'd0);
    chk("w_store_rdata_kept", rd, 32'd0);
    do_load(2, 32'h64, 32'h0000_0019, 2, "w_load");

    // Halfword store to upper lanes
    do_store(2, 32'h66, 32'hBEEF_BEEF, 4'b1100, 2, "h_store");
    do_load(2, 32'h64, 32'hBEEF_0019, 2, "h_load");

    // Byte store into a preloaded word
    do_store(2, 32'h60, 32'hAABB_CCDD, 4'hF, 2, "pre60");
    do_store(2, 32'h61, 32'h1111_1111, 4'b0010, 2, "b_store");
    do_load(2, 32'h60, 32'hAABB_11DD, 2, "b_load");

    // Illegal mask and out-of-range address leave memory alone
    do_store(2, 32'h0, 32'h1234_5678, 4'hF, 2, "pre00");
    do_bad(2, 1'b1, 32'h60, 4'b0110, "bad_mask");
    do_load(2, 32'h60, 32'hAABB_11DD, 2, "bad_mask_mem");
    do_bad(2, 1'b0, 32'h400, 4'hF, "bad_addr_ld");
    do_bad(2, 1'b1, 32'h400, 4'hF, "bad_addr_st");
    do_bad(2, 1'b0, 32'h0, 4'b0000, "bad_zero_mask");
    do_load(2, 32'h0, 32'h1234_5678, 2, "bad_addr_mem");

    // Abort with LATENCY=4: drop req after two stall cycles
    do_store(4, 32'h10, 32'h0BAD_F00D, 4'hF, 4, "pre10");
    set_in(4, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("abort_stall", {31'd0, if4.stall}, 32'd1);
      @(posedge clk); #1;
      chk("abort_ack_wait", {31'd0, if4.ack}, 32'd0);
    end
    set_in(4, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_ack", {31'd0, if4.ack}, 32'd0);
      chk("abort_state", {30'd0, st4}, 32'd0);
    end
    do_load(4, 32'h10, 32'h0BAD_F00D, 4, "abort_mem");

    // Reset asserted while a store is waiting
    do_load(2, 32'h60, 32'hAABB_11DD, 2, "rm_pre");
    set_in(2, 1'b1, 1'b1, 32'h60, 32'h0000_0000, 4'hF);
    @(posedge clk); #1;
    chk("rm_in_wait", {30'd0, st2}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rm_ack", {31'd0, if2.ack}, 32'd0);
    chk("rm_rdata", if2.rdata, 32'd0);
    chk("rm_state", {30'd0, st2}, 32'd0);
    @(posedge clk); #1;
    set_in(2, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    do_load(2, 32'h60, 32'hAABB_11DD, 2, "rm_mem");

    // Back-to-back loads with LATENCY=1 after a counter-clearing reset
    do_store(1, 32'h0, 32'hA0A0_A001, 4'hF, 1, "pre1_0");
    do_store(1, 32'h4, 32'hB0B0_B002, 4'hF, 1, "pre1_4");
    do_store(1, 32'h8, 32'hC0C0_C003, 4'hF, 1, "pre1_8");
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      chk("b2b_ack", {31'd0, if1.ack}, {31'd0, (i % 2) == 1});
      case (i)
        0: set_in(1, 1'b1, 1'b0, 32'h0, 32'd0, 4'hF);
        1: begin chk("b2b_rd0", if1.rdata, 32'hA0A0_A001); set_in(1, 1'b1, 1'b0, 32'h4, 32'd0, 4'hF); end
        3: begin chk("b2b_rd1", if1.rdata, 32'hB0B0_B002); set_in(1, 1'b1, 1'b0, 32'h8, 32'd0, 4'hF); end
        5: begin chk("b2b_rd2", if1.rdata, 32'hC0C0_C003); set_in(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0); end
        default: ;
      endcase
      #1;
      chk("b2b_stall", {31'd0, if1.stall}, {31'd0, (i % 2) == 0});
      @(posedge clk); #1;
    end
    chk("b2b_idle_ack", {31'd0, if1.ack}, 32'd0);
`ifdef DMEM_WAIT_PERF_EN
    chk("perf_rd", rd1, 32'd3);
    chk("perf_wr", wr1, 32'd0);
    chk("perf_stall", sc1, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
